// File: rtl/factorial_req_seq.sv
// factorial_req_seq: valid/ready request sequencer for the factorial core with completion timeout and overflow flag
// Ports:
//   ap_clk, ap_rst_n            clock, synchronous active-low reset
//   s_valid/s_ready/s_num/s_tag request stream (num, tag)
//   m_valid/m_ready/m_result/m_tag/m_err/m_ovf  response stream
//   core_start/core_num         to core ap_start / num
//   core_ready/core_done/core_return  from core ap_ready / ap_done / ap_return
//   busy                        high whenever not IDLE
// Optional: define FACT_OVF_BYPASS_EN to answer num > MAX_N with 0xFFFFFFFF without invoking the core.
module factorial_req_seq #(
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned TIMEOUT_CYC = 256,
   parameter int unsigned MAX_N       = 12
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [31:0]      s_num,
   input  logic [TAG_W-1:0] s_tag,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [31:0]      m_result,
   output logic [TAG_W-1:0] m_tag,
   output logic             m_err,
   output logic             m_ovf,
   output logic             core_start,
   output logic [31:0]      core_num,
   input  logic             core_ready,
   input  logic             core_done,
   input  logic [31:0]      core_return,
   output logic             busy
);
   localparam int unsigned CW = $clog2(TIMEOUT_CYC);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic tmo;
   logic req_ovf;
   // cnt holds the number of ISSUE/WAIT edges already elapsed, so this is the last allowed one
   assign tmo = cnt == CW'(TIMEOUT_CYC - 1);
   assign req_ovf = s_num > MAX_N;
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         s_ready    <= 1'b0;
         m_valid    <= 1'b0;
         m_result   <= '0;
         m_tag      <= '0;
         m_err      <= 1'b0;
         m_ovf      <= 1'b0;
         core_start <= 1'b0;
         core_num   <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (s_valid && s_ready) begin
                  s_ready  <= 1'b0;
                  busy     <= 1'b1;
                  core_num <= s_num;
                  m_tag    <= s_tag;
                  m_ovf    <= req_ovf;
                  m_err    <= 1'b0;
                  cnt      <= '0;
`ifdef FACT_OVF_BYPASS_EN
                  if (req_ovf) begin
                     state    <= OUT;
                     m_valid  <= 1'b1;
                     m_result <= '1;
                  end else begin
                     state      <= ISSUE;
                     core_start <= 1'b1;
                  end
`else
                  state      <= ISSUE;
                  core_start <= 1'b1;
`endif
               end else begin
                  s_ready <= 1'b1;
               end
            end
            ISSUE: begin
               cnt <= cnt + 1'b1;
               // done only counts once the core has taken the start
               if (core_ready && core_done) begin
                  state      <= OUT;
                  core_start <= 1'b0;
                  m_valid    <= 1'b1;
                  m_result   <= core_return;
               end else if (tmo) begin
                  state      <= OUT;
                  core_start <= 1'b0;
                  m_valid    <= 1'b1;
                  m_result   <= '0;
                  m_err      <= 1'b1;
               end else if (core_ready) begin
                  state      <= WAIT;
                  core_start <= 1'b0;
               end
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (core_done) begin
                  state    <= OUT;
                  m_valid  <= 1'b1;
                  m_result <= core_return;
               end else if (tmo) begin
                  state    <= OUT;
                  m_valid  <= 1'b1;
                  m_result <= '0;
                  m_err    <= 1'b1;
               end
            end
            OUT: begin
               if (m_ready) begin
                  state   <= IDLE;
                  m_valid <= 1'b0;
                  busy    <= 1'b0;
                  s_ready <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_factorial_req_seq.sv
// tb_factorial_req_seq: directed bench for factorial_req_seq; the bench itself plays the factorial core
module tb_factorial_req_seq;
   localparam int TAG_W = 4;
   logic ap_clk = 1'b0;
   logic ap_rst_n = 1'b0;
   logic s_valid = 1'b0;
   logic s_ready;
   logic [31:0] s_num = '0;
   logic [TAG_W-1:0] s_tag = '0;
   logic m_valid;
   logic m_ready = 1'b0;
   logic [31:0] m_result;
   logic [TAG_W-1:0] m_tag;
   logic m_err;
   logic m_ovf;
   logic core_start;
   logic [31:0] core_num;
   logic core_ready = 1'b0;
   logic core_done = 1'b0;
   logic [31:0] core_return = '0;
   logic busy;
   int passed = 0;
   int total = 0;

   factorial_req_seq #(.TAG_W(TAG_W), .TIMEOUT_CYC(16), .MAX_N(12)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_num(s_num), .s_tag(s_tag),
      .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_tag(m_tag),
      .m_err(m_err), .m_ovf(m_ovf),
      .core_start(core_start), .core_num(core_num), .core_ready(core_ready),
      .core_done(core_done), .core_return(core_return), .busy(busy)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // waits (bounded) for s_ready, then handshakes one request; returns just after the accepting edge
   task automatic send(input logic [31:0] num, input logic [TAG_W-1:0] tag);
      int n = 0;
      while (s_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      total++;
      if (s_ready !== 1'b1) $display("FAIL send_ready: s_ready=%b required 1 within 50 cycles", s_ready);
      else passed++;
      s_valid = 1'b1;
      s_num = num;
      s_tag = tag;
      tick();
      s_valid = 1'b0;
   endtask

   // core answers with ready==done after lat cycles of start
   task automatic core_reply(input int lat, input logic [31:0] ret);
      repeat (lat - 1) tick();
      core_ready = 1'b1;
      core_done = 1'b1;
      core_return = ret;
      tick();
      core_ready = 1'b0;
      core_done = 1'b0;
   endtask

   task automatic accept_resp();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      ap_rst_n = 1'b0;
      tick();
      tick();
      total++;
      if ({s_ready, m_valid, core_start, busy, m_err, m_ovf} !== 6'b0)
         $display("FAIL reset_flags: s_ready/m_valid/core_start/busy/err/ovf=%b required 000000", {s_ready, m_valid, core_start, busy, m_err, m_ovf});
      else passed++;
      total++;
      if (m_result !== 32'd0 || core_num !== 32'd0 || m_tag !== '0)
         $display("FAIL reset_data: result=%h core_num=%h tag=%h required 0", m_result, core_num, m_tag);
      else passed++;
      ap_rst_n = 1'b1;
      tick();
      total++;
      if (s_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release: s_ready=%b busy=%b required 1/0", s_ready, busy);
      else passed++;
   endtask

   task automatic test_basic();
      bit held = 1'b1;
      send(32'd5, 4'd3);
      total++;
      if (core_start !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1 || core_num !== 32'd5)
         $display("FAIL basic_issue: start=%b s_ready=%b busy=%b core_num=%0d required 1/0/1/5", core_start, s_ready, busy, core_num);
      else passed++;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (core_start !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0) held = 1'b0;
      end
      total++;
      if (!held) $display("FAIL basic_hold: core_start/s_ready/m_valid not 1/0/0 while waiting for core_ready (last %b/%b/%b)", core_start, s_ready, m_valid);
      else passed++;
      core_reply(1, 32'd120);
      total++;
      if (m_valid !== 1'b1 || m_result !== 32'd120 || m_tag !== 4'd3 || m_err !== 1'b0 || m_ovf !== 1'b0)
         $display("FAIL basic_resp: valid=%b result=%0d tag=%0d err=%b ovf=%b required 1/120/3/0/0", m_valid, m_result, m_tag, m_err, m_ovf);
      else passed++;
      total++;
      if (core_start !== 1'b0 || s_ready !== 1'b0) $display("FAIL basic_out: core_start=%b s_ready=%b required 0/0", core_start, s_ready);
      else passed++;
      accept_resp();
      total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL basic_done: valid=%b s_ready=%b busy=%b required 0/1/0", m_valid, s_ready, busy);
      else passed++;
   endtask

   task automatic test_back_to_back();
      send(32'd0, 4'd7);
      core_reply(3, 32'd1);
      total++;
      if (m_valid !== 1'b1 || m_result !== 32'd1 || m_tag !== 4'd7)
         $display("FAIL b2b_first: valid=%b result=%0d tag=%0d required 1/1/7", m_valid, m_result, m_tag);
      else passed++;
      accept_resp();
      send(32'd12, 4'd9);
      total++;
      if (core_num !== 32'd12 || core_start !== 1'b1) $display("FAIL b2b_issue: core_num=%0d start=%b required 12/1", core_num, core_start);
      else passed++;
      core_reply(4, 32'h1C8CFC00);
      total++;
      if (m_valid !== 1'b1 || m_result !== 32'h1C8CFC00 || m_tag !== 4'd9 || m_ovf !== 1'b0)
         $display("FAIL b2b_second: valid=%b result=%h tag=%0d ovf=%b required 1/1c8cfc00/9/0", m_valid, m_result, m_tag, m_ovf);
      else passed++;
      accept_resp();
   endtask

   task automatic test_backpressure();
      bit stable = 1'b1;
      send(32'd3, 4'd2);
      core_reply(2, 32'd6);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (m_valid !== 1'b1 || m_result !== 32'd6 || m_tag !== 4'd2 || m_err !== 1'b0 || m_ovf !== 1'b0 || s_ready !== 1'b0 || core_start !== 1'b0) stable = 1'b0;
      end
      total++;
      if (!stable) $display("FAIL bp_stable: valid=%b result=%0d tag=%0d s_ready=%b start=%b required 1/6/2/0/0", m_valid, m_result, m_tag, s_ready, core_start);
      else passed++;
      accept_resp();
      total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) $display("FAIL bp_release: valid=%b s_ready=%b required 0/1", m_valid, s_ready);
      else passed++;
   endtask

   task automatic test_timeout();
      bit early = 1'b0;
      send(32'd4, 4'd5);
      for (int i = 0; i < 15; i++) begin
         if (m_valid !== 1'b0) early = 1'b1;
         tick();
      end
      total++;
      if (early) $display("FAIL tmo_early: m_valid rose before 16 cycles");
      else passed++;
      total++;
      if (m_valid !== 1'b0) $display("FAIL tmo_15: m_valid=%b required 0 at 15 cycles", m_valid);
      else passed++;
      tick();
      total++;
      if (m_valid !== 1'b1 || m_err !== 1'b1 || m_result !== 32'd0 || m_tag !== 4'd5)
         $display("FAIL tmo_resp: valid=%b err=%b result=%0d tag=%0d required 1/1/0/5", m_valid, m_err, m_result, m_tag);
      else passed++;
      accept_resp();
      core_ready = 1'b1;
      core_done = 1'b1;
      core_return = 32'd24;
      tick();
      core_ready = 1'b0;
      core_done = 1'b0;
      tick();
      tick();
      total++;
      if (m_valid !== 1'b0 || core_start !== 1'b0 || busy !== 1'b0)
         $display("FAIL tmo_stray: valid=%b start=%b busy=%b required 0/0/0", m_valid, core_start, busy);
      else passed++;
   endtask

   task automatic test_ovf();
      send(32'd13, 4'd6);
`ifdef FACT_OVF_BYPASS_EN
      total++;
      if (m_valid !== 1'b1 || core_start !== 1'b0 || m_result !== 32'hFFFFFFFF || m_ovf !== 1'b1 || m_err !== 1'b0 || m_tag !== 4'd6)
         $display("FAIL ovf_bypass: valid=%b start=%b result=%h ovf=%b err=%b tag=%0d required 1/0/ffffffff/1/0/6", m_valid, core_start, m_result, m_ovf, m_err, m_tag);
      else passed++;
`else
      total++;
      if (core_start !== 1'b1 || core_num !== 32'd13) $display("FAIL ovf_issue: start=%b core_num=%0d required 1/13", core_start, core_num);
      else passed++;
      core_reply(5, 32'h7328CC00);
      total++;
      if (m_valid !== 1'b1 || m_result !== 32'h7328CC00 || m_ovf !== 1'b1 || m_err !== 1'b0 || m_tag !== 4'd6)
         $display("FAIL ovf_resp: valid=%b result=%h ovf=%b err=%b tag=%0d required 1/7328cc00/1/0/6", m_valid, m_result, m_ovf, m_err, m_tag);
      else passed++;
`endif
      accept_resp();
   endtask

   task automatic test_reset_mid();
      send(32'd6, 4'd1);
      tick();
      core_ready = 1'b1;
      tick();
      core_ready = 1'b0;
      total++;
      if (core_start !== 1'b0 || busy !== 1'b1 || m_valid !== 1'b0)
         $display("FAIL mid_wait: start=%b busy=%b valid=%b required 0/1/0", core_start, busy, m_valid);
      else passed++;
      ap_rst_n = 1'b0;
      tick();
      ap_rst_n = 1'b1;
      total++;
      if ({s_ready, m_valid, core_start, busy, m_err, m_ovf} !== 6'b0 || m_result !== 32'd0 || m_tag !== '0 || core_num !== 32'd0)
         $display("FAIL mid_reset: flags=%b result=%h tag=%h core_num=%h required all 0", {s_ready, m_valid, core_start, busy, m_err, m_ovf}, m_result, m_tag, core_num);
      else passed++;
      tick();
      total++;
      if (s_ready !== 1'b1 || busy !== 1'b0) $display("FAIL mid_release: s_ready=%b busy=%b required 1/0", s_ready, busy);
      else passed++;
      core_done = 1'b1;
      core_return = 32'd720;
      tick();
      core_done = 1'b0;
      tick();
      total++;
      if (m_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_late_done: valid=%b busy=%b required 0/0", m_valid, busy);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_timeout();
      test_ovf();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/factorial_req_seq.md
Name: factorial_req_seq

Overview:
- Request sequencer placed directly upstream of the `factorial` core. It converts a valid/ready request stream of (num, tag) into the core's ap_start/ap_ready/ap_done handshake.
- It captures ap_return and presents (result, tag, status) on a valid/ready response stream.
- It adds a completion timeout, so a hung or mis-keyed core cannot stall the pipeline, and it flags 32-bit overflow.
- One request is in flight at a time.

Parameters:
- TAG_W, 4, width of the request/response tag.
- TIMEOUT_CYC, 256, maximum cycles from first core_start to core_done before abort; must be ≥ 2.
- MAX_N, 12, largest num whose factorial fits in 32 bits; num > MAX_N sets overflow.

Ports:
- ap_clk  in  1  clock, all logic on the rising edge.
- ap_rst_n  in  1  synchronous active-low reset. The top drives the core's ap_rst = !ap_rst_n.
- s_valid  in  1  request valid.
- s_ready  out  1  request ready; high only in IDLE.
- s_num  in  32  requested n.
- s_tag  in  TAG_W  request tag.
- m_valid  out  1  response valid.
- m_ready  in  1  response ready.
- m_result  out  32  n! mod 2^32, 0 on timeout, 0xFFFFFFFF on bypass.
- m_tag  out  TAG_W  tag of the request.
- m_err  out  1  timeout abort.
- m_ovf  out  1  num > MAX_N.
- core_start  out  1  to core ap_start.
- core_num  out  32  to core num.
- core_ready  in  1  from core ap_ready.
- core_done  in  1  from core ap_done.
- core_return  in  32  from core ap_return.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (ap_rst_n=0 sampled at the edge):
  - State goes to IDLE.
  - All outputs 0 except s_ready, which is 0 during reset and 1 from the first cycle after release.
  - Timeout counter cleared.
- Reset mid-operation abandons the request silently; no response is produced.
- All outputs are registered. States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - s_ready=1.
  - On s_valid&&s_ready: latch num and tag, compute ovf = (num > MAX_N) unsigned, clear counter, go to ISSUE.
  - core_start rises on the next cycle.
- ISSUE:
  - core_start=1 and core_num held constant until core_ready is sampled 1.
  - On core_ready && !core_done: go to WAIT.
  - On core_ready && core_done in the same cycle: latch core_return, go to OUT.
  - core_done without core_ready is ignored.
- WAIT:
  - core_start=0.
  - On core_done: latch core_return, go to OUT.
- Timeout:
  - Counter increments every cycle in ISSUE/WAIT.
  - If counter == TIMEOUT_CYC-1 and no completing done that cycle: go to OUT with m_err=1, m_result=0.
  - m_valid therefore rises exactly TIMEOUT_CYC cycles after core_start first rises.
  - A done arriving on the same cycle as the timeout takes priority: normal completion, err=0.
- OUT:
  - m_valid=1; m_result, m_tag, m_err, m_ovf stable until m_ready.
  - On m_valid&&m_ready: m_valid drops next cycle, go to IDLE.
  - s_ready rises the cycle after the response handshake, so the next request is accepted one cycle later at the earliest.
- core_done or core_ready arriving in IDLE or OUT (e.g. late done after a timeout) is ignored.
- Latency:
  - Request handshake at cycle A gives core_start at A+1.
  - core_done sampled at cycle D gives m_valid at D+1.
- The result is passed through unmodified. m_ovf is informational when the core is invoked.

Optional Feature:
- Macro FACT_OVF_BYPASS_EN.
- Defined: requests with num > MAX_N never enter ISSUE. IDLE goes directly to OUT with m_result=0xFFFFFFFF, m_ovf=1, m_err=0, and m_valid at A+1. core_start stays 0.
- Undefined: every request is issued to the core; m_ovf=1 accompanies the wrapped result.

Test Plan:
- num=5, tag=3, core model with latency 6 and ready==done → core_start high from A+1 until ready; m_result=120 (0x78), m_tag=3, err=0, ovf=0; s_ready=0 from A+1 until the cycle after the response handshake.
- Back-to-back num=0 then num=12 → 1 then 479001600 (0x1C8CFC00), tags preserved, order preserved.
- Hold m_ready=0 for 10 cycles during OUT → m_valid stays 1 and data/tag/flags stay stable; s_ready=0; no second core_start.
- TIMEOUT_CYC=16, core never asserts ready/done → m_valid=1 exactly 16 cycles after core_start first high; m_err=1, m_result=0. A stray core_done later in IDLE produces no response.
- num=13, macro undefined → core invoked; m_result=1932053504 (0x7328CC00), m_ovf=1. Macro defined → core_start never asserted; m_result=0xFFFFFFFF, m_ovf=1, m_valid at A+1.
- Assert ap_rst_n=0 for 1 cycle while in WAIT → next cycle all outputs 0; after release s_ready=1 and busy=0; a late core_done yields no m_valid.
